// File: rtl/uart_rx_param.sv
// Oversampling UART receiver on the system clock: 2-flop synchroniser, baud-tick divider, mid-bit sampling.
// Each frame ends in a one-cycle rx_valid carrying data, parity and framing status; break lines cannot retrigger.
module uart_rx_param #(
  parameter int CLK_FREQ   = 1000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS + 1);

  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic                   rx_meta;
  logic                   rxs;
  logic                   armed;
  logic [DW-1:0]          div_cnt;
  logic [TW-1:0]          tick_cnt;
  logic [BW-1:0]          bit_cnt;
  logic [DATA_BITS-1:0]   shreg;
  logic                   perr;
  logic                   ferr;
  logic                   tick;
  logic                   samp;
  logic                   start_det;
  logic                   last_stop;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // START samples after half a bit; every later sample is a full bit further on.
  assign tick      = (div_cnt == DIV_LAST);
  assign samp      = tick && (tick_cnt == ((state == START) ? HALF_LAST : FULL_LAST));
  assign start_det = (state == IDLE) && armed && !rxs;
  assign last_stop = samp && (state == STOP) && (bit_cnt == STOP_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_det) state_nxt = START;
      START:   if (samp) state_nxt = rxs ? IDLE : DATA;
      DATA:    if (samp && (bit_cnt == DATA_LAST)) state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:  if (samp) state_nxt = STOP;
      STOP:    if (last_stop) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    rx_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      armed      <= 1'b0;
      div_cnt    <= '0;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      perr       <= 1'b0;
      ferr       <= 1'b0;
      rx_data    <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      // Restarting the divider on the start edge phase-aligns every tick to that edge.
      if (start_det || tick) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      if (start_det || samp) begin
        tick_cnt <= '0;
      end else if (tick) begin
        tick_cnt <= tick_cnt + 1'b1;
      end

      if (start_det || (samp && (state_nxt != state))) begin
        bit_cnt <= '0;
      end else if (samp) begin
        bit_cnt <= bit_cnt + 1'b1;
      end

      // A line that never returns high after a frame (break) must not look like a new start.
      if ((state == IDLE) && rxs) begin
        armed <= 1'b1;
      end else if ((state == START) && samp && !rxs) begin
        armed <= 1'b0;
      end

      if (samp && (state == DATA)) begin
        shreg <= {rxs, shreg[DATA_BITS-1:1]};
      end

      if (start_det) begin
        perr <= 1'b0;
      end else if (samp && (state == PARITY)) begin
        perr <= ^shreg ^ rxs ^ (PARITY_ODD != 0);
      end

      if (start_det) begin
        ferr <= 1'b0;
      end else if (samp && (state == STOP) && !rxs) begin
        ferr <= 1'b1;
      end

      if (last_stop) begin
        rx_data    <= shreg;
        parity_err <= perr;
        frame_err  <= ferr | ~rxs;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: four configurations (8N1, 8E1, 7N2, 9O1) driven from a frame-level model
// that predicts payload, parity and framing status from the bits placed on the line.
module tb_uart_rx_param;

  localparam int CF      = 1600000;
  localparam int BR      = 10000;
  localparam int BIT_CLK = 160;

  typedef struct {int idx; logic [8:0] data; logic pe; logic fe; int t;} cap_t;
  typedef struct {int idx; logic [8:0] data; logic pe; logic fe;} exp_t;

  int nbits  [4] = '{8, 8, 7, 9};
  int par_en [4] = '{0, 1, 0, 1};
  int par_odd[4] = '{0, 0, 0, 1};
  int nstop  [4] = '{1, 1, 2, 1};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_line [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
  logic [7:0] d0;
  logic [7:0] d1;
  logic [6:0] d2;
  logic [8:0] d3;
  logic [3:0] v;
  logic [3:0] pe;
  logic [3:0] fe;
  logic [3:0] bz;

  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  cap_t caps[$];
  exp_t expq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_param #(.CLK_FREQ(CF), .BAUD_RATE(BR), .OVERSAMPLE(16), .DATA_BITS(8),
                  .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .rx(rx_line[0]), .rx_data(d0), .rx_valid(v[0]),
    .parity_err(pe[0]), .frame_err(fe[0]), .busy(bz[0]));

  uart_rx_param #(.CLK_FREQ(CF), .BAUD_RATE(BR), .OVERSAMPLE(16), .DATA_BITS(8),
                  .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .rx(rx_line[1]), .rx_data(d1), .rx_valid(v[1]),
    .parity_err(pe[1]), .frame_err(fe[1]), .busy(bz[1]));

  uart_rx_param #(.CLK_FREQ(CF), .BAUD_RATE(BR), .OVERSAMPLE(16), .DATA_BITS(7),
                  .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u2 (
    .clk(clk), .rst(rst), .rx(rx_line[2]), .rx_data(d2), .rx_valid(v[2]),
    .parity_err(pe[2]), .frame_err(fe[2]), .busy(bz[2]));

  uart_rx_param #(.CLK_FREQ(CF), .BAUD_RATE(BR), .OVERSAMPLE(16), .DATA_BITS(9),
                  .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u3 (
    .clk(clk), .rst(rst), .rx(rx_line[3]), .rx_data(d3), .rx_valid(v[3]),
    .parity_err(pe[3]), .frame_err(fe[3]), .busy(bz[3]));

  always @(negedge clk) begin
    if (v[0]) caps.push_back('{0, {1'b0, d0}, pe[0], fe[0], cyc});
    if (v[1]) caps.push_back('{1, {1'b0, d1}, pe[1], fe[1], cyc});
    if (v[2]) caps.push_back('{2, {2'b0, d2}, pe[2], fe[2], cyc});
    if (v[3]) caps.push_back('{3, d3, pe[3], fe[3], cyc});
  end

  task automatic drive_bit(input int k, input logic b);
    rx_line[k] = b;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  // Expected status comes from counting ones over data+parity and from the stop level on the line.
  task automatic send_frame(input int k, input logic [8:0] data, input logic pbit, input logic stopv);
    exp_t       e;
    logic [8:0] m;
    m      = data & 9'((1 << nbits[k]) - 1);
    e.idx  = k;
    e.data = m;
    e.pe   = (par_en[k] != 0) && ((($countones(m) + int'(pbit)) % 2) != par_odd[k]);
    e.fe   = !stopv;
    expq.push_back(e);
    drive_bit(k, 1'b0);
    for (int i = 0; i < nbits[k]; i++) drive_bit(k, m[i]);
    if (par_en[k] != 0) drive_bit(k, pbit);
    for (int i = 0; i < nstop[k]; i++) drive_bit(k, stopv);
  endtask

  function automatic logic good_par(input int k, input logic [8:0] data);
    int ones;
    ones = $countones(data & 9'((1 << nbits[k]) - 1));
    return (par_odd[k] != 0) ? (ones % 2 == 0) : (ones % 2 == 1);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if ({d0, d1, d2, d3, v, pe, fe, bz} !== '0) begin
      bad++;
      $display("FAIL reset_hold outputs=%h want=0", {d0, d1, d2, d3, v, pe, fe, bz});
    end
    rst = 1'b0;
    repeat (20) @(negedge clk);
    total++;
    if (({d0, d1, d2, d3, v, pe, fe, bz} !== '0) || (caps.size() != 0)) begin
      bad++;
      $display("FAIL reset_release outputs=%h frames=%0d want=0/0", {d0, d1, d2, d3, v, pe, fe, bz}, caps.size());
    end
  endtask

  task automatic test_basic();
    int   t0;
    cap_t c;
    exp_t e;
    t0 = cyc;
    send_frame(0, 9'h0A5, 1'b0, 1'b1);
    repeat (2 * BIT_CLK) @(negedge clk);
    total++;
    if (caps.size() != 1) begin
      bad++;
      $display("FAIL basic_count got=%0d want=1", caps.size());
    end
    if (caps.size() > 0) begin
      total++;
      if ((caps[0].t - t0 < 1519) || (caps[0].t - t0 > 1527)) begin
        bad++;
        $display("FAIL basic_latency got=%0d want=1523+-4", caps[0].t - t0);
      end
    end
    total++;
    if (bz[0] !== 1'b0) begin
      bad++;
      $display("FAIL basic_busy got=%b want=0", bz[0]);
    end
    while (caps.size() > 0 && expq.size() > 0) begin
      c = caps.pop_front();
      e = expq.pop_front();
      total++;
      if (c.idx != e.idx || c.data !== e.data || c.pe !== e.pe || c.fe !== e.fe) begin
        bad++;
        $display("FAIL basic_frame got=%0d/%h/%b/%b want=%0d/%h/%b/%b", c.idx, c.data, c.pe, c.fe, e.idx, e.data, e.pe, e.fe);
      end
    end
    caps.delete();
    expq.delete();
  endtask

  task automatic test_glitch();
    cap_t c;
    exp_t e;
    rx_line[0] = 1'b0;
    repeat (20) @(negedge clk);
    total++;
    if (bz[0] !== 1'b1) begin
      bad++;
      $display("FAIL glitch_busy_rise got=%b want=1", bz[0]);
    end
    repeat (20) @(negedge clk);
    rx_line[0] = 1'b1;
    repeat (BIT_CLK) @(negedge clk);
    total++;
    if (bz[0] !== 1'b0 || caps.size() != 0) begin
      bad++;
      $display("FAIL glitch_reject busy=%b frames=%0d want=0/0", bz[0], caps.size());
    end
    send_frame(0, 9'h05A, 1'b0, 1'b1);
    repeat (2 * BIT_CLK) @(negedge clk);
    total++;
    if (caps.size() != 1) begin
      bad++;
      $display("FAIL glitch_next_count got=%0d want=1", caps.size());
    end
    while (caps.size() > 0 && expq.size() > 0) begin
      c = caps.pop_front();
      e = expq.pop_front();
      total++;
      if (c.idx != e.idx || c.data !== e.data || c.pe !== e.pe || c.fe !== e.fe) begin
        bad++;
        $display("FAIL glitch_next got=%0d/%h/%b/%b want=%0d/%h/%b/%b", c.idx, c.data, c.pe, c.fe, e.idx, e.data, e.pe, e.fe);
      end
    end
    caps.delete();
    expq.delete();
  endtask

  task automatic test_parity();
    cap_t c;
    exp_t e;
    send_frame(1, 9'h003, 1'b1, 1'b1);
    repeat (BIT_CLK) @(negedge clk);
    send_frame(1, 9'h003, 1'b0, 1'b1);
    repeat (2 * BIT_CLK) @(negedge clk);
    total++;
    if (caps.size() != 2) begin
      bad++;
      $display("FAIL parity_count got=%0d want=2", caps.size());
    end
    while (caps.size() > 0 && expq.size() > 0) begin
      c = caps.pop_front();
      e = expq.pop_front();
      total++;
      if (c.idx != e.idx || c.data !== e.data || c.pe !== e.pe || c.fe !== e.fe) begin
        bad++;
        $display("FAIL parity_frame got=%0d/%h/%b/%b want=%0d/%h/%b/%b", c.idx, c.data, c.pe, c.fe, e.idx, e.data, e.pe, e.fe);
      end
    end
    caps.delete();
    expq.delete();
  endtask

  task automatic test_break();
    cap_t c;
    exp_t e;
    send_frame(0, 9'h081, 1'b0, 1'b0);
    repeat (2000) @(negedge clk);
    total++;
    if (caps.size() != 1 || bz[0] !== 1'b0) begin
      bad++;
      $display("FAIL break_hold frames=%0d busy=%b want=1/0", caps.size(), bz[0]);
    end
    rx_line[0] = 1'b1;
    repeat (BIT_CLK) @(negedge clk);
    send_frame(0, 9'h03C, 1'b0, 1'b1);
    repeat (2 * BIT_CLK) @(negedge clk);
    total++;
    if (caps.size() != 2) begin
      bad++;
      $display("FAIL break_count got=%0d want=2", caps.size());
    end
    while (caps.size() > 0 && expq.size() > 0) begin
      c = caps.pop_front();
      e = expq.pop_front();
      total++;
      if (c.idx != e.idx || c.data !== e.data || c.pe !== e.pe || c.fe !== e.fe) begin
        bad++;
        $display("FAIL break_frame got=%0d/%h/%b/%b want=%0d/%h/%b/%b", c.idx, c.data, c.pe, c.fe, e.idx, e.data, e.pe, e.fe);
      end
    end
    caps.delete();
    expq.delete();
  endtask

  // Aborted payload 0xF3: bits 4..7 are 1, so the rest of the frame cannot form a new start edge.
  task automatic test_reset_mid_frame();
    cap_t       c;
    exp_t       e;
    logic [7:0] ab;
    ab = 8'hF3;
    drive_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(0, ab[i]);
    rx_line[0] = 1'b1;
    repeat (BIT_CLK / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({d0, v[0], pe[0], fe[0], bz[0]} !== '0) begin
      bad++;
      $display("FAIL midreset_outputs got=%h want=0", {d0, v[0], pe[0], fe[0], bz[0]});
    end
    rst = 1'b0;
    repeat (BIT_CLK / 2 - 1) @(negedge clk);
    for (int i = 5; i < 8; i++) drive_bit(0, ab[i]);
    drive_bit(0, 1'b1);
    repeat (2 * BIT_CLK) @(negedge clk);
    total++;
    if (caps.size() != 0 || bz[0] !== 1'b0) begin
      bad++;
      $display("FAIL midreset_abort frames=%0d busy=%b want=0/0", caps.size(), bz[0]);
    end
    send_frame(0, 9'h0C3, 1'b0, 1'b1);
    repeat (2 * BIT_CLK) @(negedge clk);
    total++;
    if (caps.size() != 1) begin
      bad++;
      $display("FAIL midreset_count got=%0d want=1", caps.size());
    end
    while (caps.size() > 0 && expq.size() > 0) begin
      c = caps.pop_front();
      e = expq.pop_front();
      total++;
      if (c.idx != e.idx || c.data !== e.data || c.pe !== e.pe || c.fe !== e.fe) begin
        bad++;
        $display("FAIL midreset_frame got=%0d/%h/%b/%b want=%0d/%h/%b/%b", c.idx, c.data, c.pe, c.fe, e.idx, e.data, e.pe, e.fe);
      end
    end
    caps.delete();
    expq.delete();
  endtask

  task automatic test_back_to_back();
    cap_t       c;
    exp_t       e;
    logic [8:0] vals [3];
    int         insts[3];
    vals  = '{9'h000, 9'h0FF, 9'h055};
    insts = '{0, 2, 1};
    for (int j = 0; j < 3; j++) begin
      for (int n = 0; n < 3; n++) send_frame(insts[j], vals[n], good_par(insts[j], vals[n]), 1'b1);
      repeat (2 * BIT_CLK) @(negedge clk);
    end
    total++;
    if (caps.size() != 9) begin
      bad++;
      $display("FAIL b2b_count got=%0d want=9", caps.size());
    end
    while (caps.size() > 0 && expq.size() > 0) begin
      c = caps.pop_front();
      e = expq.pop_front();
      total++;
      if (c.idx != e.idx || c.data !== e.data || c.pe !== e.pe || c.fe !== e.fe) begin
        bad++;
        $display("FAIL b2b_frame got=%0d/%h/%b/%b want=%0d/%h/%b/%b", c.idx, c.data, c.pe, c.fe, e.idx, e.data, e.pe, e.fe);
      end
    end
    caps.delete();
    expq.delete();
  endtask

  task automatic test_random();
    cap_t       c;
    exp_t       e;
    int         k;
    int         gap;
    logic [8:0] d;
    logic       pbad;
    logic       sbad;
    for (int n = 0; n < 10; n++) begin
      k    = (n < 6) ? 3 : 1;
      d    = 9'($urandom_range(0, 511));
      pbad = ($urandom_range(0, 3) == 0);
      sbad = ($urandom_range(0, 4) == 0);
      // After a low stop bit the line has to go high again before the next start is accepted.
      gap  = sbad ? $urandom_range(20, 200) : $urandom_range(0, 100);
      send_frame(k, d, good_par(k, d) ^ pbad, !sbad);
      rx_line[k] = 1'b1;
      repeat (gap) @(negedge clk);
    end
    repeat (2 * BIT_CLK) @(negedge clk);
    total++;
    if (caps.size() != 10) begin
      bad++;
      $display("FAIL random_count got=%0d want=10", caps.size());
    end
    while (caps.size() > 0 && expq.size() > 0) begin
      c = caps.pop_front();
      e = expq.pop_front();
      total++;
      if (c.idx != e.idx || c.data !== e.data || c.pe !== e.pe || c.fe !== e.fe) begin
        bad++;
        $display("FAIL random_frame got=%0d/%h/%b/%b want=%0d/%h/%b/%b", c.idx, c.data, c.pe, c.fe, e.idx, e.data, e.pe, e.fe);
      end
    end
    caps.delete();
    expq.delete();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_glitch();
    test_parity();
    test_break();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Parametrised, oversampling UART receiver. It replaces the fixed 8N1 receiver that runs on a derived clock.
- Runs on the single system clock using an internal baud-tick enable. No generated clocks.
- Configurable data width, parity and stop bits. Samples at mid-bit, rejects false starts, and flags parity and framing errors.
- Feeds the UART datapath (rx FIFO / register block) through a one-cycle valid strobe.

Parameters:
- CLK_FREQ, 1000000: system clock frequency in Hz.
- BAUD_RATE, 9600: line bit rate.
- OVERSAMPLE, 16: ticks per bit. Must be even and >=4.
- DATA_BITS, 8: payload bits per frame. Legal range 5..9.
- PARITY_EN, 0: 1 means a parity bit follows the data.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd. Ignored when PARITY_EN=0.
- STOP_BITS, 1: number of stop bits checked, 1 or 2.

Ports:
- clk, input, 1: system clock. All logic is on posedge clk.
- rst, input, 1: synchronous, active-high reset.
- rx, input, 1: asynchronous serial line. Idles high.
- rx_data, output, DATA_BITS: last received payload, LSB = first bit on the line.
- rx_valid, output, 1: one-cycle pulse when rx_data/parity_err/frame_err update.
- parity_err, output, 1: parity mismatch on the last frame. Always 0 when PARITY_EN=0.
- frame_err, output, 1: a stop bit sampled 0 on the last frame.
- busy, output, 1: high from start detection until return to IDLE.

Behaviour:
- Reset: all outputs 0; synchroniser flops = 1; state IDLE; armed = 0; tick and bit counters 0. Reset mid-frame aborts the frame with no rx_valid.
- Synchroniser: 2-flop on rx. All decisions use the synchronised value rxs. Line-to-detect latency is 2 clk.
- Tick generator:
  - DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), integer division, must be >=1.
  - tick pulses 1 clk every DIV clocks.
  - The divider restarts at 0 on start detection so that sampling is phase-aligned to the falling edge.
- IDLE:
  - busy=0.
  - armed is set when rxs==1.
  - If armed and rxs==0: go to START, busy=1, clear tick counter.
  - Armed prevents retriggering on a held-low line (break) after a framing error.
- START: at tick OVERSAMPLE/2, sample rxs.
  - If 1 (glitch): return to IDLE with no output; armed stays 1.
  - If 0: go to DATA, clear armed.
- DATA:
  - Sample every OVERSAMPLE ticks, i.e. at mid-bit.
  - Shift LSB-first into the shift register.
  - After DATA_BITS samples, go to PARITY if PARITY_EN, else STOP.
- PARITY:
  - Sample one bit.
  - perr = XOR(data bits, parity bit) XOR PARITY_ODD. Even parity expects total XOR 0.
- STOP:
  - Sample STOP_BITS bits, each OVERSAMPLE ticks apart.
  - ferr = 1 if any stop sample is 0.
  - On the clock after the final stop sample: rx_data <= shift register, parity_err <= perr, frame_err <= ferr, rx_valid=1 for exactly 1 clk, go to IDLE.
- Error flags and rx_data hold until the next rx_valid; they are not sticky across frames.
- A good frame is delivered even when ferr/perr are set; data is never dropped silently.
- Back-to-back frames: IDLE is re-entered at mid-stop-bit. A start edge arriving half a bit later must be caught, so there is zero idle gap between frames.
- No parity or framing error suppresses the next frame, except through the armed rule.
- Frame latency: rx_valid is asserted about (1 + DATA_BITS + PARITY_EN + STOP_BITS - 0.5) bit times + 3 clk after the falling start edge.

Test Plan (CLK_FREQ=1600000, BAUD_RATE=10000, OVERSAMPLE=16 -> DIV=10, 160 clk/bit):
- 8N1, drive 0xA5 then idle -> exactly one rx_valid, rx_data=0xA5, parity_err=0, frame_err=0, busy low afterwards.
- Start glitch: rx low for 40 clk then high -> no rx_valid, busy returns 0 within 1 bit time. A following 0x5A frame is received correctly.
- PARITY_EN=1, PARITY_ODD=0:
  - Send 0x03 with parity bit 1 -> rx_data=0x03, parity_err=1.
  - Resend with parity bit 0 -> parity_err=0.
- Framing/break: send 0x81 with stop bit 0, then hold rx low 2000 clk -> one rx_valid with frame_err=1, rx_data=0x81, no further rx_valid during the low period. After rx high for 1 bit, 0x3C is received with frame_err=0.
- Reset mid-frame: assert rst for 1 clk during data bit 4 -> all outputs 0, no rx_valid for that frame. The next frame 0xC3 is received correctly.
- Back-to-back frames 0x00, 0xFF, 0x55 with no idle gap, plus STOP_BITS=2 and DATA_BITS=7 variants -> three rx_valid pulses in order, correct values masked to DATA_BITS, all error flags 0.
